// File: rtl/gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv
// N:1 WIDTH-bit mux with registered output and a blanked, glitch-free select-switch sequencer.
// Latency: 1 cycle input-to-Z in IDLE; a switch freezes Z for BLANK+1 edges before the new channel shows.
// Backpressure: none; loads arriving during HOLD or with an unchanged select are dropped, out-of-range loads set ERR.
module gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(
    parameter int WIDTH = 1,
    parameter int NCH   = 2,
    parameter int SELW  = 1,
    parameter int BLANK = 1
) (
    input  logic                 CLK,
    input  logic                 RN,
    input  logic [NCH*WIDTH-1:0] I,
    input  logic [SELW-1:0]      S,
    input  logic                 SLD,
    input  logic                 ECLR,
    output logic [WIDTH-1:0]     Z,
    output logic [SELW-1:0]      SCUR,
    output logic                 BUSY,
    output logic                 ERR,
    inout  wire                  VDD,
    inout  wire                  VSS
);

    localparam logic [SELW:0] NCH_W   = NCH[SELW:0];
    localparam logic [3:0]    BLANK_C = BLANK[3:0];

    typedef enum logic {IDLE, HOLD} state_t;

    state_t          state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [SELW-1:0] pend, pend_nxt, scur_nxt;
    logic            busy_nxt, err_nxt, z_load, s_oor;
    logic [WIDTH-1:0] ch_dat;
    logic            unused_supply;

    assign unused_supply = VDD ^ VSS;
    assign s_oor         = ({1'b0, S} >= NCH_W);

    always_comb begin
        ch_dat = '0;
        for (int k = 0; k < NCH; k++) begin
            if (SCUR == SELW'(k)) ch_dat = I[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend;
        scur_nxt  = SCUR;
        busy_nxt  = BUSY;
        z_load    = 1'b0;
        // Set takes priority over clear when both land on the same edge.
        err_nxt   = ERR;
        if (ECLR)         err_nxt = 1'b0;
        if (SLD && s_oor) err_nxt = 1'b1;

        case (state)
            IDLE: begin
                if (SLD && !s_oor && (S != SCUR)) begin
                    pend_nxt = S;
                    if (BLANK == 0) begin
                        scur_nxt = S;
                    end else begin
                        state_nxt = HOLD;
                        cnt_nxt   = BLANK_C;
                        busy_nxt  = 1'b1;
                    end
                end else begin
                    z_load = 1'b1;
                end
            end
            HOLD: begin
                if (cnt == 4'd1) begin
                    scur_nxt  = pend;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            SCUR  <= '0;
            BUSY  <= 1'b0;
            ERR   <= 1'b0;
            Z     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
            SCUR  <= scur_nxt;
            BUSY  <= busy_nxt;
            ERR   <= err_nxt;
            if (z_load) Z <= ch_dat;
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync.sv
// Bench for the blanked N:1 mux: three builds (4ch/BLANK=2, 3ch/BLANK=2, 4ch/BLANK=0).
module tb_gf180mcu_fd_sc_mcu9t5v0__muxn_sync;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn;
    wire  vdd, vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    // Build A: WIDTH=8, NCH=4, BLANK=2
    logic [31:0] ia;
    logic [1:0]  sa, scura;
    logic        slda, eclra, busya, erra;
    logic [7:0]  za;
    // Build B: WIDTH=8, NCH=3, BLANK=2
    logic [23:0] ib;
    logic [1:0]  sb, scurb;
    logic        sldb, eclrb, busyb, errb;
    logic [7:0]  zb;
    // Build C: WIDTH=8, NCH=4, BLANK=0
    logic [31:0] ic;
    logic [1:0]  sc, scurc;
    logic        sldc, eclrc, busyc, errc;
    logic [7:0]  zc;

    gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.WIDTH(8), .NCH(4), .SELW(2), .BLANK(2)) dut_a (
        .CLK(clk), .RN(rn), .I(ia), .S(sa), .SLD(slda), .ECLR(eclra),
        .Z(za), .SCUR(scura), .BUSY(busya), .ERR(erra), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.WIDTH(8), .NCH(3), .SELW(2), .BLANK(2)) dut_b (
        .CLK(clk), .RN(rn), .I(ib), .S(sb), .SLD(sldb), .ECLR(eclrb),
        .Z(zb), .SCUR(scurb), .BUSY(busyb), .ERR(errb), .VDD(vdd), .VSS(vss));
    gf180mcu_fd_sc_mcu9t5v0__muxn_sync #(.WIDTH(8), .NCH(4), .SELW(2), .BLANK(0)) dut_c (
        .CLK(clk), .RN(rn), .I(ic), .S(sc), .SLD(sldc), .ECLR(eclrc),
        .Z(zc), .SCUR(scurc), .BUSY(busyc), .ERR(errc), .VDD(vdd), .VSS(vss));

    int checks   = 0;
    int failures = 0;
    logic [7:0] zq[$];
    logic [7:0] exp_z;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rn = 1'b0;
        ia = '0; sa = '0; slda = 1'b0; eclra = 1'b0;
        ib = '0; sb = '0; sldb = 1'b0; eclrb = 1'b0;
        ic = '0; sc = '0; sldc = 1'b0; eclrc = 1'b0;
        #2;
        checks++;
        if ({za, scura, busya, erra} !== 12'h000) begin
            failures++;
            $display("FAIL reset_a: z=%h scur=%0d busy=%b err=%b, need all 0", za, scura, busya, erra);
        end
        checks++;
        if ({zb, scurb, busyb, errb, zc, scurc, busyc, errc} !== 24'h0) begin
            failures++;
            $display("FAIL reset_bc: zb=%h errb=%b zc=%h scurc=%0d, need all 0", zb, errb, zc, scurc);
        end
        tick();
        rn = 1'b1;
        tick();
    endtask

    task automatic test_pass_through();
        ia[7:0] = 8'h5A;
        zq.push_back(8'h5A);
        tick();
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z) begin failures++; $display("FAIL pass_5a: z=%h need %h", za, exp_z); end
        ia[7:0] = 8'hA5;
        zq.push_back(8'hA5);
        tick();
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z) begin failures++; $display("FAIL pass_a5: z=%h need %h", za, exp_z); end
    endtask

    task automatic test_async_reset();
        ia = '0;
        ia[7:0]   = 8'h3C;
        ia[23:16] = 8'h77;
        zq.push_back(8'h3C);
        tick();
        exp_z = zq.pop_front();
        sa = 2'd2; slda = 1'b1;
        zq.push_back(8'h3C);
        tick();
        slda = 1'b0;
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z || busya !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre: z=%h busy=%b need %h/1", za, busya, exp_z);
        end
        #2 rn = 1'b0;
        #1;
        checks++;
        if ({za, scura, busya, erra} !== 12'h000) begin
            failures++;
            $display("FAIL arst_async: z=%h scur=%0d busy=%b err=%b need all 0", za, scura, busya, erra);
        end
        rn = 1'b1;
        zq.push_back(8'h3C);
        tick();
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z || scura !== 2'd0) begin
            failures++;
            $display("FAIL arst_release: z=%h scur=%0d need %h/0", za, scura, exp_z);
        end
    endtask

    task automatic test_reset_mid_hold();
        ia[7:0]   = 8'h44;
        ia[23:16] = 8'h55;
        zq.push_back(8'h44);
        tick();
        exp_z = zq.pop_front();
        sa = 2'd2; slda = 1'b1;
        zq.push_back(8'h44);
        tick();
        slda = 1'b0;
        exp_z = zq.pop_front();
        zq.push_back(8'h44);
        tick();
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z || busya !== 1'b1) begin
            failures++;
            $display("FAIL hold_pre: z=%h busy=%b need %h/1", za, busya, exp_z);
        end
        #2 rn = 1'b0;
        #1 rn = 1'b1;
        ia[7:0] = 8'h66;
        for (int k = 0; k < 3; k++) begin
            zq.push_back(8'h66);
            tick();
            exp_z = zq.pop_front();
            checks++;
            if (za !== exp_z || scura !== 2'd0 || busya !== 1'b0) begin
                failures++;
                $display("FAIL hold_rst_%0d: z=%h scur=%0d busy=%b need %h/0/0", k, za, scura, busya, exp_z);
            end
        end
    endtask

    task automatic test_switch();
        ia = '0;
        ia[7:0]   = 8'h11;
        ia[23:16] = 8'h22;
        zq.push_back(8'h11);
        tick();
        exp_z = zq.pop_front();
        sa = 2'd2; slda = 1'b1;
        zq.push_back(8'h11);
        tick(); // t0
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z || busya !== 1'b1 || scura !== 2'd0) begin
            failures++;
            $display("FAIL sw_t0: z=%h busy=%b scur=%0d need %h/1/0", za, busya, scura, exp_z);
        end
        // Retarget attempt and channel-0 change during HOLD must both be invisible.
        sa = 2'd3; slda = 1'b1;
        ia[7:0] = 8'h99;
        zq.push_back(8'h11);
        tick(); // t0+1
        slda = 1'b0;
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z || busya !== 1'b1 || scura !== 2'd0) begin
            failures++;
            $display("FAIL sw_t1: z=%h busy=%b scur=%0d need %h/1/0", za, busya, scura, exp_z);
        end
        zq.push_back(8'h11);
        tick(); // t0+2
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z || busya !== 1'b0 || scura !== 2'd2) begin
            failures++;
            $display("FAIL sw_t2: z=%h busy=%b scur=%0d need %h/0/2", za, busya, scura, exp_z);
        end
        zq.push_back(8'h22);
        tick(); // t0+3
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z || scura !== 2'd2) begin
            failures++;
            $display("FAIL sw_t3: z=%h scur=%0d need %h/2", za, scura, exp_z);
        end
        ia[23:16] = 8'h33;
        zq.push_back(8'h33);
        tick();
        exp_z = zq.pop_front();
        checks++;
        if (za !== exp_z) begin failures++; $display("FAIL sw_live: z=%h need %h", za, exp_z); end
    endtask

    task automatic test_same_select();
        sa = 2'd2; slda = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ia[23:16] = 8'h40 + 8'(k);
            zq.push_back(8'h40 + 8'(k));
            tick();
            exp_z = zq.pop_front();
            checks++;
            if (za !== exp_z || busya !== 1'b0) begin
                failures++;
                $display("FAIL same_sel_%0d: z=%h busy=%b need %h/0", k, za, busya, exp_z);
            end
        end
        slda = 1'b0;
    endtask

    task automatic test_err();
        ib = '0;
        ib[7:0] = 8'h12;
        sb = 2'd3; sldb = 1'b1;
        tick();
        checks++;
        if (errb !== 1'b1 || scurb !== 2'd0 || zb !== 8'h12 || busyb !== 1'b0) begin
            failures++;
            $display("FAIL err_set: err=%b scur=%0d z=%h busy=%b need 1/0/12/0", errb, scurb, zb, busyb);
        end
        ib[7:0] = 8'h34;
        tick();
        checks++;
        if (errb !== 1'b1 || zb !== 8'h34) begin
            failures++;
            $display("FAIL err_track: err=%b z=%h need 1/34", errb, zb);
        end
        eclrb = 1'b1;
        tick();
        checks++;
        if (errb !== 1'b1) begin failures++; $display("FAIL err_set_wins: err=%b need 1", errb); end
        sldb = 1'b0;
        tick();
        checks++;
        if (errb !== 1'b0) begin failures++; $display("FAIL err_clr: err=%b need 0", errb); end
        eclrb = 1'b0;
        tick();
        checks++;
        if (errb !== 1'b0 || scurb !== 2'd0) begin
            failures++;
            $display("FAIL err_idle: err=%b scur=%0d need 0/0", errb, scurb);
        end
    endtask

    task automatic test_blank0();
        ic = '0;
        ic[7:0]  = 8'h10;
        ic[15:8] = 8'h20;
        tick();
        checks++;
        if (zc !== 8'h10) begin failures++; $display("FAIL b0_pre: z=%h need 10", zc); end
        sc = 2'd1; sldc = 1'b1;
        ic[7:0] = 8'h15;
        tick();
        sldc = 1'b0;
        checks++;
        if (scurc !== 2'd1 || zc !== 8'h10 || busyc !== 1'b0) begin
            failures++;
            $display("FAIL b0_accept: scur=%0d z=%h busy=%b need 1/10/0", scurc, zc, busyc);
        end
        tick();
        checks++;
        if (zc !== 8'h20 || busyc !== 1'b0) begin
            failures++;
            $display("FAIL b0_new: z=%h busy=%b need 20/0", zc, busyc);
        end
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_async_reset();
        test_reset_mid_hold();
        test_switch();
        test_same_select();
        test_err();
        test_blank0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
